high_radix_mult_seq: RTL

HIGH_RADIX_MULT_SEQ -- requirements
Module: high_radix_mult_seq

---
 rtl/high_radix_mult_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/high_radix_mult_seq.sv
// rtl/high_radix_mult_seq.sv - radix-4 Booth sequential multiplier, one digit per cycle
module high_radix_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out
);

  // Operands are widened by two bits so the final digit absorbs the unsigned
  // MSB; that gives WIDTH/2+1 digits. The accumulator carries four guard bits
  // above the product so no partial sum wraps before truncation.
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int YW   = WIDTH + 3;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [AW-1:0]       mcand_q, mcand_d;
  logic [YW-1:0]       ybits_q, ybits_d;
  logic [2*WIDTH-1:0]  out_q, out_d;

  logic                accept;
  logic                last_digit;
  logic [2:0]          win;
  logic [AW-1:0]       pp;
  logic [AW-1:0]       sum;
  logic [AW-1:0]       x_ext;
  logic [YW-1:0]       y_ext;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_digit = (cnt_q == CW'(NDIG - 1));
  assign win        = ybits_q[2:0];

  // signed_mode only matters at accept time: it is folded into the extension
  // bits here, so no separate mode register is kept.
  assign x_ext = {{(AW - WIDTH){signed_mode & x[WIDTH-1]}}, x};
  assign y_ext = {{2{signed_mode & y[WIDTH-1]}}, y, 1'b0};

  // Booth digit decode into a partial product against the running multiplicand
  always_comb begin
    pp = '0;
    unique case (win)
      3'b000, 3'b111: pp = '0;
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      default:        pp = -mcand_q;
    endcase
  end

  assign sum = acc_q + pp;

  // State register and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      ybits_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      ybits_q <= ybits_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic: accept in IDLE, fixed-length CALC, hold in DONE until taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_digit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on accept, retire one digit per CALC cycle
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    ybits_d = ybits_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = x_ext;
          ybits_d = y_ext;
        end
      end
      CALC: begin
        cnt_d   = cnt_q + 1'b1;
        acc_d   = sum;
        mcand_d = mcand_q << 2;
        ybits_d = {2'b00, ybits_q[YW-1:2]};
        if (last_digit) out_d = sum[2*WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out       = out_q;
  end

endmodule
